// File: rtl/isp_ccm_if.sv
// Pixel stream bundle for isp_ccm: line/frame/pixel strobes plus one RGB sample.
interface isp_ccm_if #(
  parameter int BITS = 8
);
  logic            href;
  logic            vsync;
  logic            de;
  logic [BITS-1:0] r;
  logic [BITS-1:0] g;
  logic [BITS-1:0] b;

  modport master (output href, vsync, de, r, g, b);
  modport slave  (input  href, vsync, de, r, g, b);
endinterface

// File: rtl/isp_ccm.sv
// 3x3 colour-correction matrix, 3-cycle pipeline (multiply, row sum, round/clamp).
// The coefficient/bypass set is double-buffered and switches only on a vsync rising edge.
module isp_ccm #(
  parameter int BITS   = 8,
  parameter int COEF_W = 12,
  parameter int FRAC   = 8
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic [9*COEF_W-1:0] cfg_coef,
  input  logic                cfg_bypass,
  input  logic                cfg_update,
  output logic                cfg_active,
  isp_ccm_if.slave            pix_in,
  isp_ccm_if.master           pix_out
);

  localparam int PW = BITS + 1 + COEF_W;  // signed product width
  localparam int SW = PW + 2;             // row-sum width, holds three products plus rounding
  localparam logic [COEF_W-1:0]   UNITY = COEF_W'(1) << FRAC;
  localparam logic [COEF_W-1:0]   ZERO  = '0;
  localparam logic [9*COEF_W-1:0] IDENT = {UNITY, ZERO, ZERO, ZERO, UNITY, ZERO, ZERO, ZERO, UNITY};
  localparam logic signed [SW-1:0] RND  = SW'(1) << (FRAC - 1);

  logic                vs_q;
  logic [9*COEF_W-1:0] act_coef;
  logic                act_bypass;
  logic                load;
  logic [9*COEF_W-1:0] coef_s1;
  logic                byp_s1;

  // A load takes effect for the pixel sampled on the vsync edge itself, so S1 sees the new set directly.
  assign load    = pix_in.vsync & ~vs_q & cfg_update;
  assign coef_s1 = load ? cfg_coef   : act_coef;
  assign byp_s1  = load ? cfg_bypass : act_bypass;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      act_coef   <= IDENT;
      act_bypass <= 1'b0;
      cfg_active <= 1'b0;
    end else begin
      vs_q       <= pix_in.vsync;
      cfg_active <= load;
      if (load) begin
        act_coef   <= cfg_coef;
        act_bypass <= cfg_bypass;
      end
    end
  end

  logic [BITS-1:0] comp [3];

  always_comb begin
    comp[0] = pix_in.r;
    comp[1] = pix_in.g;
    comp[2] = pix_in.b;
  end

  logic signed [PW-1:0] prod [9];
  logic signed [SW-1:0] sum  [3];
  logic [2:0]           sync1, sync2;
  logic                 byp1, byp2;
  logic [3*BITS-1:0]    raw1, raw2;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 9; k++) prod[k] <= '0;
      sync1 <= '0;
      byp1  <= 1'b0;
      raw1  <= '0;
    end else begin
      for (int unsigned k = 0; k < 9; k++)
        prod[k] <= PW'($signed({1'b0, comp[k % 3]})) * PW'($signed(coef_s1[k*COEF_W +: COEF_W]));
      sync1 <= {pix_in.href, pix_in.vsync, pix_in.de};
      byp1  <= byp_s1;
      raw1  <= {pix_in.r, pix_in.g, pix_in.b};
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) sum[i] <= '0;
      sync2 <= '0;
      byp2  <= 1'b0;
      raw2  <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++)
        sum[i] <= SW'(prod[3*i]) + SW'(prod[3*i+1]) + SW'(prod[3*i+2]) + RND;
      sync2 <= sync1;
      byp2  <= byp1;
      raw2  <= raw1;
    end
  end

  logic signed [SW-1:0] shifted [3];
  logic [BITS-1:0]      sat     [3];

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      shifted[i] = sum[i] >>> FRAC;
      sat[i]     = shifted[i][BITS-1:0];
      if (shifted[i][SW-1])
        sat[i] = '0;
      else if (|shifted[i][SW-2:BITS])
        sat[i] = '1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out.href  <= 1'b0;
      pix_out.vsync <= 1'b0;
      pix_out.de    <= 1'b0;
      pix_out.r     <= '0;
      pix_out.g     <= '0;
      pix_out.b     <= '0;
    end else begin
      {pix_out.href, pix_out.vsync, pix_out.de} <= sync2;
      if (!sync2[0]) begin
        pix_out.r <= '0;
        pix_out.g <= '0;
        pix_out.b <= '0;
      end else if (byp2) begin
        {pix_out.r, pix_out.g, pix_out.b} <= raw2;
      end else begin
        pix_out.r <= sat[0];
        pix_out.g <= sat[1];
        pix_out.b <= sat[2];
      end
    end
  end

endmodule

// File: tb/tb_isp_ccm.sv
// Directed plus randomized bench for isp_ccm against an integer reference of the matrix stage.
module tb_isp_ccm;
  localparam int BITS   = 8;
  localparam int COEF_W = 12;
  localparam int FRAC   = 8;

  logic                pclk       = 1'b0;
  logic                rst_n      = 1'b1;
  logic [9*COEF_W-1:0] cfg_coef   = '0;
  logic                cfg_bypass = 1'b0;
  logic                cfg_update = 1'b0;
  logic                cfg_active;

  isp_ccm_if #(.BITS(BITS)) in_if ();
  isp_ccm_if #(.BITS(BITS)) out_if ();

  isp_ccm #(.BITS(BITS), .COEF_W(COEF_W), .FRAC(FRAC)) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .cfg_coef   (cfg_coef),
    .cfg_bypass (cfg_bypass),
    .cfg_update (cfg_update),
    .cfg_active (cfg_active),
    .pix_in     (in_if),
    .pix_out    (out_if)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int href;
    int vsync;
    int de;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t q[$];
  int   cm[9];
  int   cb;
  int   m[9];
  int   mb;
  int   mvs;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{default: 0};
    for (int k = 0; k < 9; k++) m[k] = (k % 4 == 0) ? 256 : 0;
    mb  = 0;
    mvs = 0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  task automatic pack();
    for (int k = 0; k < 9; k++) cfg_coef[k*COEF_W +: COEF_W] = COEF_W'(cm[k]);
    cfg_bypass = (cb != 0);
  endtask

  task automatic set_rows(input int c0, input int c1, input int c2, input int byp);
    for (int i = 0; i < 3; i++) begin
      cm[3*i]   = c0;
      cm[3*i+1] = c1;
      cm[3*i+2] = c2;
    end
    cb = byp;
    pack();
  endtask

  // One pixel clock: evaluate the reference for the current inputs, then compare the output due now.
  task automatic cycle();
    exp_t e;
    int   ea;
    int   c[3];
    int   rgb[3];
    int   s;
    ea = (in_if.vsync === 1'b1 && mvs == 0 && cfg_update === 1'b1) ? 1 : 0;
    if (ea != 0) begin
      m  = cm;
      mb = cb;
    end
    mvs  = int'(in_if.vsync);
    c[0] = int'(in_if.r);
    c[1] = int'(in_if.g);
    c[2] = int'(in_if.b);
    for (int i = 0; i < 3; i++) begin
      s = 128;
      for (int j = 0; j < 3; j++) s += c[j] * m[3*i+j];
      rgb[i] = (in_if.de !== 1'b1) ? 0 : (mb != 0) ? c[i] : clamp(s >>> 8);
    end
    e.href  = int'(in_if.href);
    e.vsync = int'(in_if.vsync);
    e.de    = int'(in_if.de);
    e.r     = rgb[0];
    e.g     = rgb[1];
    e.b     = rgb[2];
    q.push_back(e);
    @(posedge pclk);
    @(negedge pclk);
    e = q.pop_front();
    chk("out_href",   32'(out_if.href),  32'(e.href));
    chk("out_vsync",  32'(out_if.vsync), 32'(e.vsync));
    chk("out_de",     32'(out_if.de),    32'(e.de));
    chk("out_r",      32'(out_if.r),     32'(e.r));
    chk("out_g",      32'(out_if.g),     32'(e.g));
    chk("out_b",      32'(out_if.b),     32'(e.b));
    chk("cfg_active", 32'(cfg_active),   32'(ea));
  endtask

  task automatic drive(input int r, input int g, input int b, input int de, input int href, input int vs);
    in_if.r     = BITS'(r);
    in_if.g     = BITS'(g);
    in_if.b     = BITS'(b);
    in_if.de    = (de != 0);
    in_if.href  = (href != 0);
    in_if.vsync = (vs != 0);
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_href",   32'(out_if.href),  32'd0);
    chk("rst_vsync",  32'(out_if.vsync), 32'd0);
    chk("rst_de",     32'(out_if.de),    32'd0);
    chk("rst_r",      32'(out_if.r),     32'd0);
    chk("rst_g",      32'(out_if.g),     32'd0);
    chk("rst_b",      32'(out_if.b),     32'd0);
    chk("rst_active", 32'(cfg_active),   32'd0);
    model_reset();
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
  endtask

  initial begin
    in_if.r = '0; in_if.g = '0; in_if.b = '0;
    in_if.de = 1'b0; in_if.href = 1'b0; in_if.vsync = 1'b0;
    set_rows(0, 0, 0, 0);
    #2;
    do_reset();

    // identity after reset
    for (int i = 0; i < 6; i++) drive(200, 100, 50, 1, 1, 0);

    // load [384,-64,-64] on a frame edge
    set_rows(384, -64, -64, 0);
    cfg_update = 1'b1;
    drive(100, 100, 100, 1, 0, 1);
    cfg_update = 1'b0;
    drive(200, 50, 50, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);

    // negative clamp
    set_rows(-256, 0, 0, 0);
    cfg_update = 1'b1;
    drive(10, 20, 30, 1, 1, 1);
    cfg_update = 1'b0;
    drive(10, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);

    // rounding with 0.5
    set_rows(128, 0, 0, 0);
    cfg_update = 1'b1;
    drive(3, 3, 3, 1, 1, 1);
    cfg_update = 1'b0;
    for (int i = 0; i < 3; i++) drive(3, 0, 0, 1, 1, 0);

    // update held high without a frame edge, then the edge arrives
    set_rows(0, 256, 0, 0);
    cfg_update = 1'b1;
    for (int i = 0; i < 5; i++) drive(40, 80, 120, 1, 1, 0);
    drive(40, 80, 120, 1, 1, 1);
    cfg_update = 1'b0;
    for (int i = 0; i < 4; i++) drive(40, 80, 120, 1, 1, 1);

    // bypass with a non-identity matrix, plus de gating
    set_rows(100, -300, 700, 1);
    cfg_update = 1'b1;
    drive(17, 34, 51, 1, 1, 0);
    drive(17, 34, 51, 1, 1, 1);
    cfg_update = 1'b0;
    drive(99, 88, 77, 0, 1, 1);
    drive(17, 34, 51, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(5, 6, 7, 0, 0, 0);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 9; k++) cm[k] = int'($urandom_range(0, 1279)) - 512;
      cb = ($urandom_range(0, 3) == 0) ? 1 : 0;
      pack();
      cfg_update = ($urandom_range(0, 3) != 0);
      drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)), 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      for (int p = 0; p < 24; p++) begin
        if ($urandom_range(0, 7) == 0) begin
          for (int k = 0; k < 9; k++) cm[k] = int'($urandom_range(0, 4095)) - 2048;
          pack();
        end
        cfg_update = ($urandom_range(0, 1) == 1);
        drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)), 0);
      end
    end

    // mid-frame reset with a pending update; identity must come back
    set_rows(300, 20, -40, 0);
    cfg_update = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    cfg_update = 1'b0;
    for (int i = 0; i < 4; i++) drive(120, 60, 30, 1, 1, 0);
    set_rows(-100, 500, 9, 1);
    cfg_update = 1'b1;
    do_reset();
    cfg_update = 1'b0;
    drive(200, 100, 50, 1, 1, 1);
    for (int i = 0; i < 5; i++) drive(200, 100, 50, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/isp_ccm.md
Name: isp_ccm

Overview:
- 3x3 colour-correction matrix stage. Sits directly downstream of ISP_awb_top and upstream of ISP_interconnect/hdmi_tx in the pixel_clk domain.
- Consumes 8-bit R/G/B plus in_href/in_vsync/in_de. Produces corrected, saturated R/G/B with syncs delayed by the same fixed latency.
- Coefficients are double-buffered: the active set changes only at frame start, so no frame mixes two matrices.

Parameters:
- BITS, 8: colour component width.
- COEF_W, 12: signed coefficient width, fixed point Q3.8 (256 = 1.0; range -8.0 .. +7.996).
- FRAC, 8: fractional bits of coefficients.

Ports:
- pclk  input  1  pixel clock (pixel_clk domain).
- rst_n  input  1  asynchronous active-low reset.
- cfg_coef  input  9*COEF_W  packed matrix. Slice k = [k*COEF_W +: COEF_W]. Order k = 0..8 is m00,m01,m02,m10,m11,m12,m20,m21,m22. Row 0 produces R, row 1 G, row 2 B; column order is R,G,B.
- cfg_bypass  input  1  1 = pass pixels unchanged (syncs still delayed).
- cfg_update  input  1  level: 1 = load cfg_coef/cfg_bypass into the active set at the next frame start.
- in_href  input  1  line valid.
- in_vsync  input  1  frame sync, active high.
- in_de  input  1  pixel valid.
- in_r, in_g, in_b  input  BITS each  input pixel.
- out_href, out_vsync, out_de  output  1 each  syncs delayed by 3 cycles.
- out_r, out_g, out_b  output  BITS each  corrected pixel.
- cfg_active  output  1  pulses high for 1 cycle when the shadow set is loaded.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0.
  - Pipeline registers 0.
  - Active matrix = identity (m00 = m11 = m22 = 256, others 0).
  - Active bypass = 0.
  - Stored vsync history = 0.
- Frame start: rising edge of in_vsync, i.e. in_vsync = 1 and the registered previous value = 0.
  - If cfg_update = 1 in that same cycle, the active set <= {cfg_coef, cfg_bypass} at that clock edge.
  - cfg_active = 1 in the following cycle only.
  - If cfg_update = 0, the active set is unchanged.
  - cfg_coef changes at any other time have no effect on output.
- Pipeline, fixed latency 3 cycles from input sample to output. Applies to every output, including syncs and in bypass.
  - S1: nine products p_ij = signed({1'b0,c_j}) * m_ij; each product is 21-bit signed.
  - S2: row sum s_i = p_i0 + p_i1 + p_i2 + 128 (rounding). Sum is 23-bit signed and cannot overflow.
  - S3: v_i = s_i >>> FRAC (arithmetic shift). Clamp: v < 0 gives 0; v > 255 gives 255; otherwise v.
- Pixel gating:
  - If the delayed de = 0 at S3, out_r/g/b = 0 regardless of the data path.
  - In bypass, out = input delayed 3 cycles, with the same de gating.
- Active-set timing:
  - The active set is sampled at S1.
  - A load at frame start affects the pixel sampled in the same cycle as the vsync edge and all later pixels. Pixels already in the pipeline complete with the old set.
- Back-to-back pixels are accepted every cycle. There is no stall or backpressure.
- Reset asserted mid-frame:
  - Outputs go to 0 immediately (asynchronously).
  - After release, the first 3 output cycles carry out_de = 0.
  - The active set returns to identity and any pending update is lost.
- Simultaneous vsync rising edge and cfg_update toggling in the same cycle: the value of cfg_update sampled at that edge decides whether the load occurs.

Test Plan:
- Reset release then identity stream: in_r/g/b = (200,100,50), de = 1 → 3 cycles later out = (200,100,50) and out_de = 1. Syncs are delayed exactly 3 cycles.
- Load at frame start: cfg_coef = all-row [384,-64,-64], cfg_update = 1, vsync rising; pixel (100,100,100) → out = (100,100,100). Then pixel (200,50,50): R = (76800-3200-3200+128)>>8 = 275 → 255. G and B (rows equal) → 255.
- Negative clamp and rounding: m = row [-256,0,0]; input R = 10 → out channel = 0. m = row [128,0,0] (0.5); input 3 → (384+128)>>8 = 2.
- Update without frame edge: change cfg_coef with cfg_update = 1 while in_vsync stays 0 → output is unchanged and cfg_active stays 0. At the next vsync rising edge the load occurs and cfg_active pulses for exactly 1 cycle.
- Bypass plus de gating: cfg_bypass loaded as 1 with a non-identity matrix; input (17,34,51), de = 1 → out (17,34,51) after 3 cycles. Input with de = 0 and nonzero data → out = 0.
- Mid-frame reset: assert rst_n low during an active line → outputs 0 in the same cycle. After release, identity is restored and the first 3 cycles have out_de = 0.
